// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the decode-stage hazard sequencer.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_HAZ   = 2'd1,
        HZ_FLUSH = 2'd2,
        HZ_MWAIT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/ALU/writeback view seen by the hazard sequencer, plus its stall/flush decisions.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 32
);
    logic             d_valid;
    logic [REG_W-1:0] d_read_sel1;
    logic [REG_W-1:0] d_read_sel2;
    logic             d_uses_rs1;
    logic             d_uses_rs2;
    logic [REG_W-1:0] d_write_sel;
    logic             d_is_wb;
    logic             d_is_load;
    logic             br_en;
    logic             mem_busy;
    logic             wb_en;
    logic [REG_W-1:0] wb_sel;

    logic             issue;
    logic             stall;
    logic             flush_f;
    logic             flush_d;
    logic [NREG-1:0]  pending;
    logic [1:0]       state;

    modport master (
        output d_valid, d_read_sel1, d_read_sel2, d_uses_rs1, d_uses_rs2,
               d_write_sel, d_is_wb, d_is_load, br_en, mem_busy, wb_en, wb_sel,
        input  issue, stall, flush_f, flush_d, pending, state
    );

    modport slave (
        input  d_valid, d_read_sel1, d_read_sel2, d_uses_rs1, d_uses_rs2,
               d_write_sel, d_is_wb, d_is_load, br_en, mem_busy, wb_en, wb_sel,
        output issue, stall, flush_f, flush_d, pending, state
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-result bit per architectural register; x0 never pending, set beats clear.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_sel,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_sel,
    input  logic [REG_W-1:0] rd_sel1,
    input  logic [REG_W-1:0] rd_sel2,
    output logic [NREG-1:0]  pending,
    output logic             rd_pend1,
    output logic             rd_pend2
);

    logic [NREG-1:0] bits_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bits_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (set_en && int'(set_sel) == r)
                    bits_q[r] <= 1'b1;
                else if (clr_en && int'(clr_sel) == r)
                    bits_q[r] <= 1'b0;
            end
            bits_q[0] <= 1'b0;
        end
    end

    assign pending  = bits_q;
    assign rd_pend1 = bits_q[rd_sel1];
    assign rd_pend2 = bits_q[rd_sel2];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencer: issue / hazard stall / branch flush / memory freeze, Mealy outputs.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter bit LOAD_ONLY    = 1'b1
) (
    input logic         clock,
    input logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t        state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             brp_q, brp_nx;
    logic             issue_c, stall_c, ff_c, fd_c, run_eval;
    logic             pend1, pend2, hazard, sb_set;
    logic [NREG-1:0]  sb_bits;

    hazard_scoreboard #(.NREG(NREG)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (sb_set),
        .set_sel  (bus.d_write_sel),
        .clr_en   (bus.wb_en),
        .clr_sel  (bus.wb_sel),
        .rd_sel1  (bus.d_read_sel1),
        .rd_sel2  (bus.d_read_sel2),
        .pending  (sb_bits),
        .rd_pend1 (pend1),
        .rd_pend2 (pend2)
    );

    assign hazard = bus.d_valid &
                    ((bus.d_uses_rs1 & (bus.d_read_sel1 != '0) & pend1) |
                     (bus.d_uses_rs2 & (bus.d_read_sel2 != '0) & pend2));

    // ALU results are forwarded, so only loads need tracking unless LOAD_ONLY is off
    assign sb_set = issue_c & ~reset & bus.d_is_wb & (bus.d_write_sel != '0) &
                    (bus.d_is_load | ~LOAD_ONLY);

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        brp_nx   = brp_q;
        issue_c  = 1'b0;
        stall_c  = 1'b0;
        ff_c     = 1'b0;
        fd_c     = 1'b0;
        run_eval = 1'b0;

        case (state_q)
            HZ_RUN, HZ_HAZ: run_eval = 1'b1;
            HZ_FLUSH: begin
                // br_en and mem_busy here belong to squashed work; flush dominates
                ff_c = 1'b1;
                fd_c = 1'b1;
                if (cnt_q == '0) state_nx = HZ_RUN;
                else             cnt_nx   = cnt_q - 1'b1;
            end
            HZ_MWAIT: begin
                if (bus.mem_busy) begin
                    stall_c = 1'b1;
                    if (bus.br_en) brp_nx = 1'b1;
                end else if (brp_q) begin
                    ff_c     = 1'b1;
                    fd_c     = 1'b1;
                    brp_nx   = 1'b0;
                    cnt_nx   = CNT_LOAD;
                    state_nx = HZ_FLUSH;
                end else begin
                    run_eval = 1'b1;
                end
            end
            default: state_nx = HZ_RUN;
        endcase

        if (run_eval) begin
            if (bus.br_en) begin
                ff_c     = 1'b1;
                fd_c     = 1'b1;
                cnt_nx   = CNT_LOAD;
                state_nx = HZ_FLUSH;
            end else if (bus.mem_busy) begin
                stall_c  = 1'b1;
                state_nx = HZ_MWAIT;
            end else if (hazard) begin
                stall_c  = 1'b1;
                fd_c     = 1'b1;
                state_nx = HZ_HAZ;
            end else begin
                issue_c  = bus.d_valid;
                state_nx = HZ_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            brp_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            brp_q   <= brp_nx;
        end
    end

    assign bus.issue   = issue_c & ~reset;
    assign bus.stall   = stall_c & ~reset;
    assign bus.flush_f = ff_c & ~reset;
    assign bus.flush_d = fd_c & ~reset;
    assign bus.pending = reset ? '0 : sb_bits;
    assign bus.state   = reset ? HZ_RUN : state_q;

endmodule
